tmds_period_sequencer: RTL and testbench

- Timing and period scheduler for one HDMI/DVI TMDS link.
- Generates raster counters, sync and data enable.
- Decides per pixel slot what the three TMDS encoders send: control tokens, video preamble, video guard band or active pixel data.
- Runs in the pixel clock domain. Its outputs feed the TMDS encoders, whose 10-bit words go to the per-channel serializers running at clk_x10.

---
 rtl/tmds_period_sequencer.sv | 129 ++++++++++++
 tb/tb_tmds_period_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/tmds_period_sequencer.sv
// tmds_period_sequencer: raster timing and TMDS period scheduler (control/preamble/guard/video).
// Define TMDS_VIDEO_PREAMBLE_EN for HDMI periods; undefined gives plain DVI control/video.
module tmds_period_sequencer #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [11:0] hcnt,
   output logic [11:0] vcnt,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic [1:0]  ch_mode,
   output logic [3:0]  ctl,
   output logic        pix_rd,
   output logic        frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [11:0] HA  = 12'(H_ACTIVE);
   localparam logic [11:0] HT1 = 12'(H_TOTAL - 1);
   localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VA  = 12'(V_ACTIVE);
   localparam logic [11:0] VT1 = 12'(V_TOTAL - 1);
   localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
`ifdef TMDS_VIDEO_PREAMBLE_EN
   localparam logic [11:0] HPRE = 12'(H_TOTAL - 10);
   localparam logic [11:0] HGB  = 12'(H_TOTAL - 2);
   localparam logic [11:0] VA1  = 12'(V_ACTIVE - 1);
`endif

   typedef enum logic [2:0] {
      CTRL     = 3'd0,
      PREAMBLE = 3'd1,
      GUARD    = 3'd2,
      VIDEO    = 3'd3,
      IDLE     = 3'd4
   } state_t;

   state_t      state, state_d;
   logic [11:0] nh, nv, nnh, nnv;
   logic        de_d, pix_d, hs_d, vs_d, fs_d;
   logic [1:0]  mode_d;
   logic [3:0]  ctl_d;
`ifdef TMDS_VIDEO_PREAMBLE_EN
   logic        pre_go;
`endif

   // Everything is computed for the slot about to be registered (nh,nv), so all outputs stay aligned.
   always_comb begin
      nh = 12'd0;
      nv = 12'd0;
      if (en && state != IDLE) begin
         nh = (hcnt == HT1) ? 12'd0 : hcnt + 12'd1;
         nv = (hcnt != HT1) ? vcnt : (vcnt == VT1) ? 12'd0 : vcnt + 12'd1;
      end
      nnh = (nh == HT1) ? 12'd0 : nh + 12'd1;
      nnv = (nh != HT1) ? nv : (nv == VT1) ? 12'd0 : nv + 12'd1;
      de_d  = en && nh < HA && nv < VA;
      pix_d = en && nnh < HA && nnv < VA;
      hs_d  = en && nh >= HS0 && nh < HS1;
      vs_d  = en && nv >= VS0 && nv < VS1;
      fs_d  = en && nh == 12'd0 && nv == 12'd0;
`ifdef TMDS_VIDEO_PREAMBLE_EN
      pre_go = nh == HPRE && (nv == VT1 || nv < VA1);
`endif
      state_d = state;
      if (!en)
         state_d = IDLE;
      else
         case (state)
            IDLE: state_d = CTRL;
`ifdef TMDS_VIDEO_PREAMBLE_EN
            CTRL:     if (pre_go) state_d = PREAMBLE;
            PREAMBLE: if (nh == HGB) state_d = GUARD;
            GUARD:    if (nh == 12'd0) state_d = VIDEO;
            VIDEO:    if (nh == HA) state_d = pre_go ? PREAMBLE : CTRL;
`else
            CTRL:     if (nh == 12'd0 && nv < VA) state_d = VIDEO;
            VIDEO:    if (nh == HA) state_d = CTRL;
`endif
            default: state_d = CTRL;
         endcase
      mode_d = (state_d == IDLE) ? 2'd0 : state_d[1:0];
`ifdef TMDS_VIDEO_PREAMBLE_EN
      ctl_d = {3'b000, state_d == PREAMBLE};
`else
      ctl_d = 4'd0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         hcnt        <= 12'd0;
         vcnt        <= 12'd0;
         de          <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         ch_mode     <= 2'd0;
         ctl         <= 4'd0;
         pix_rd      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_d;
         hcnt        <= nh;
         vcnt        <= nv;
         de          <= de_d;
         hsync       <= hs_d ? HS_POL : ~HS_POL;
         vsync       <= vs_d ? VS_POL : ~VS_POL;
         ch_mode     <= mode_d;
         ctl         <= ctl_d;
         pix_rd      <= pix_d;
         frame_start <= fs_d;
      end
   end
endmodule

// File: tb/tb_tmds_period_sequencer.sv
// tb_tmds_period_sequencer: directed bench on a 20x5 raster, both HDMI and DVI builds.
module tb_tmds_period_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [11:0] hcnt, vcnt;
   logic        de, hsync, vsync, pix_rd, frame_start;
   logic [1:0]  ch_mode;
   logic [3:0]  ctl;
   int          checks = 0;
   int          failures = 0;
   int          pulses[2];
   int          fs_n = 0, fs_first = -1, fs_last = -1;

   always #5 clk = ~clk;

   tmds_period_sequencer #(
      .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(12),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .hcnt(hcnt), .vcnt(vcnt), .de(de), .hsync(hsync), .vsync(vsync),
      .ch_mode(ch_mode), .ctl(ctl), .pix_rd(pix_rd), .frame_start(frame_start)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " hcnt"}, int'(hcnt), 0);
      chk({tag, " vcnt"}, int'(vcnt), 0);
      chk({tag, " de"}, int'(de), 0);
      chk({tag, " hsync"}, int'(hsync), 1);
      chk({tag, " vsync"}, int'(vsync), 1);
      chk({tag, " ch_mode"}, int'(ch_mode), 0);
      chk({tag, " ctl"}, int'(ctl), 0);
      chk({tag, " pix_rd"}, int'(pix_rd), 0);
      chk({tag, " frame_start"}, int'(frame_start), 0);
   endtask

   // first: line v=0 right after leaving idle, which had no preamble in front of it
   task automatic chk_slot(input int h, input int v, input bit first);
      string t;
      bit    act, pre_line;
      int    m;
      t = $sformatf("h%0d v%0d", h, v);
      act = h < 4 && v < 2;
      pre_line = v == 4 || v == 0;
`ifdef TMDS_VIDEO_PREAMBLE_EN
      m = act ? (first ? 0 : 3) : (pre_line && h >= 10 && h <= 17) ? 1 : (pre_line && h >= 18) ? 2 : 0;
`else
      m = (act && !first) ? 3 : 0;
`endif
      chk({t, " hcnt"}, int'(hcnt), h);
      chk({t, " vcnt"}, int'(vcnt), v);
      chk({t, " de"}, int'(de), int'(act));
      chk({t, " hsync"}, int'(hsync), (h == 6 || h == 7) ? 0 : 1);
      chk({t, " vsync"}, int'(vsync), (v == 3) ? 0 : 1);
      chk({t, " frame_start"}, int'(frame_start), (h == 0 && v == 0) ? 1 : 0);
      chk({t, " pix_rd"}, int'(pix_rd), ((h < 3 && v < 2) || (h == 19 && pre_line)) ? 1 : 0);
      chk({t, " ch_mode"}, int'(ch_mode), m);
      chk({t, " ctl"}, int'(ctl), (m == 1) ? 1 : 0);
   endtask

   initial begin
      pulses[0] = 0;
      pulses[1] = 0;
      repeat (3) @(negedge clk);
      chk_idle("rst");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_idle("en_low");
      en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         chk_slot(c % 20, (c / 20) % 5, c < 20);
         if (pix_rd) pulses[c / 100]++;
         if (frame_start) begin
            fs_n++;
            if (fs_first < 0) fs_first = c;
            fs_last = c;
         end
      end
      chk("pix_rd pulses frame0", pulses[0], 8);
      chk("pix_rd pulses frame1", pulses[1], 8);
      chk("frame_start count", fs_n, 2);
      chk("frame_start first", fs_first, 0);
      chk("frame_start spacing", fs_last - fs_first, 100);
      for (int h = 0; h <= 14; h++) begin
         @(negedge clk);
         chk_slot(h, 0, 1'b0);
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_idle($sformatf("drop%0d", i));
      end
      en = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         chk_slot(c % 20, c / 20, c < 20);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
